instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 193 +++++++++++++++++++
 tb/tb_instr_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Assembles UART bytes into instruction words and writes them to instruction memory.
// Optional trailing-checksum check is compiled in with INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned         NB_BYTE   = 8,
  parameter int unsigned         NB_INSTR  = 32,
  parameter int unsigned         NB_ADDR   = 10,
  parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [NB_BYTE-1:0]  CMD_LOAD  = 8'h4C,
  parameter logic [NB_BYTE-1:0]  CMD_RESET = 8'h52
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_wr_en,
  output logic [NB_ADDR-1:0]  o_wr_addr,
  output logic [NB_INSTR-1:0] o_wr_data,
  output logic                o_load_done,
  output logic                o_overflow,
  output logic                o_busy,
  output logic                o_cksum_err
);

  localparam int unsigned NB_BYTES = NB_INSTR / NB_BYTE;
  localparam int unsigned NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int unsigned NB_SHIFT = NB_INSTR - NB_BYTE;
  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] ADDR_MAX  = '1;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, CKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
  logic [NB_SHIFT-1:0]   shift_q, shift_d;
  logic [NB_ADDR-1:0]    addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0]    wr_addr_q, wr_addr_d;
  logic [NB_INSTR-1:0]   wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic [NB_INSTR-1:0]   word;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]    xor_q, xor_d;
  logic                  err_q, err_d;
`endif

  // Earlier bytes sit in the upper lanes, so the first byte ends up in the MSBs.
  assign word = {shift_q, i_rx_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
          state_d = LOAD;
          cnt_d   = '0;
          shift_d = '0;
          addr_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      LOAD: begin
        if (i_rx_valid) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ i_rx_data;
`endif
          if (cnt_q == LAST_BYTE) begin
            cnt_d     = '0;
            shift_d   = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word;
            if (addr_q != ADDR_MAX) addr_d = addr_q + NB_ADDR'(1);
            // HALT at the last address is a clean finish, not an overflow.
            if (word == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state_d = CKSUM;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end else if (addr_q == ADDR_MAX) begin
              state_d = DONE;
              done_d  = 1'b1;
              ovf_d   = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + NB_CNT'(1);
            shift_d = word[NB_SHIFT-1:0];
          end
        end
      end

      DONE: begin
        if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
          state_d = IDLE;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          addr_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
`endif
        end
      end

`ifdef INSTR_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (i_rx_valid) begin
          err_d   = (i_rx_data != xor_q);
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef INSTR_LOADER_CHECKSUM_EN
    busy_d = (state_d == LOAD) || (state_d == CKSUM);
`else
    busy_d = (state_d == LOAD);
`endif
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_load_done = done_q;
  assign o_overflow  = ovf_q;
  assign o_busy      = busy_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign o_cksum_err = err_q;
`else
  assign o_cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader with a 4-word memory so overflow is reachable.
module tb_instr_loader;

  localparam int unsigned NA = 2;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic HALT_DONE = 1'b0;
`else
  localparam logic HALT_DONE = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [NA-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          load_done, overflow, busy, cksum_err;

  typedef struct packed {
    logic [NA-1:0] addr;
    logic [31:0]   data;
    logic          done;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  instr_loader #(.NB_ADDR(NA)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_load_done(load_done),
    .o_overflow (overflow),
    .o_busy     (busy),
    .o_cksum_err(cksum_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", wr_data, e.data);
          check("wr_done", 32'(load_done), 32'(e.done));
          check("wr_ovf", 32'(overflow), 32'(e.ovf));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic expect_wr,
                           input logic [NA-1:0] a, input logic done, input logic ovf);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_wr) begin
        e.addr = a; e.data = w; e.done = done; e.ovf = ovf;
        sb.push_back(e);
      end
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_levels(input string tag, input logic d, input logic o,
                              input logic b, input logic c);
    check({tag, "_load_done"}, 32'(load_done), 32'(d));
    check({tag, "_overflow"}, 32'(overflow), 32'(o));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_cksum_err"}, 32'(cksum_err), 32'(c));
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check_levels("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // Stray bytes before the load command must be ignored.
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    check("idle_busy", 32'(busy), 32'd0);

    send_byte(8'h4C);
    check("load_busy", 32'(busy), 32'd1);
    send_word(32'h2008_0005, 1'b1, 2'd0, 1'b0, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b1, 2'd1, HALT_DONE, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("cksum_busy", 32'(busy), 32'd1);
    send_byte(8'h2D);
`endif
    idle(1);
    check_levels("halt", 1'b1, 1'b0, 1'b0, 1'b0);

    // In DONE only CMD_RESET is honoured.
    send_byte(8'h4C);
    send_word(32'h1122_3344, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(1);
    check_levels("done_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h52);
    idle(1);
    check_levels("rearm", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-word discards the partial bytes.
    send_byte(8'h4C);
    send_word(32'h0A0B_0C0D, 1'b1, 2'd0, 1'b0, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h4C);
    send_word(32'h0102_0304, 1'b1, 2'd0, 1'b0, 1'b0);
    // Command bytes inside a word are plain data; last address overflows.
    send_word(32'h4C52_4C52, 1'b1, 2'd1, 1'b0, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 1'b0);
    send_word(32'h1234_5678, 1'b1, 2'd3, 1'b1, 1'b1);
    send_word(32'h8765_4321, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(1);
    check_levels("ovf", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h52);
    idle(1);
    check_levels("ovf_clear", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h4C);
      send_word(32'h0102_0304, 1'b1, 2'd0, 1'b0, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b1, 2'd1, 1'b0, 1'b0);
      idle(1);
      check("ck_pre_done", 32'(load_done), 32'd0);
      send_byte((k == 0) ? 8'h04 : 8'h05);
      idle(1);
      check_levels((k == 0) ? "ck_good" : "ck_bad", 1'b1, 1'b0, 1'b0, 1'(k));
      send_byte(8'h52);
      idle(1);
      check("ck_clear", 32'(cksum_err), 32'd0);
    end
`endif

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
